// File: rtl/seq_div.sv
// seq_div: sequential radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// The divider produces one quotient bit per cycle. Its results are registered
// and hold until the next operation completes.
module seq_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             L,
  input  logic             Signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;      // partial remainder
  logic [WIDTH-1:0] dq;       // dividend magnitude, shifts into quotient
  logic [WIDTH-1:0] dmag;     // divisor magnitude
  logic             qneg;
  logic             rneg;
  logic [CW-1:0]    count;

  logic             div_zero;
  logic             ovf;
  logic             special;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;

  // Operand classification, magnitudes and one restoring-division step.
  always_comb begin
    div_zero = (divisor == '0);
    ovf      = Signed && (dividend == MINV) && (divisor == '1);
    special  = div_zero || ovf;
    a_mag    = (Signed && dividend[WIDTH-1]) ? -dividend : dividend;
    b_mag    = (Signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    shifted  = {acc, dq[WIDTH-1]};
    trial    = shifted - {1'b0, dmag};
    qbit     = ~trial[WIDTH];
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. Special cases skip CALC and finish in FIX.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (L) state_nxt = special ? FIX : CALC;
      CALC: if (count == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and outputs. The special-case results are preloaded into the
  // magnitude registers with both signs cleared. FIX then writes them back
  // unchanged, so every path shares the same result write.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      quotient  <= '0;
      remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      count     <= '0;
      acc       <= '0;
      dq        <= '0;
      dmag      <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (L) begin
            if (div_zero) begin
              dq   <= '1;
              acc  <= dividend;
              qneg <= 1'b0;
              rneg <= 1'b0;
            end else if (ovf) begin
              dq   <= dividend;
              acc  <= '0;
              qneg <= 1'b0;
              rneg <= 1'b0;
            end else begin
              dq    <= a_mag;
              dmag  <= b_mag;
              acc   <= '0;
              qneg  <= Signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              rneg  <= Signed && dividend[WIDTH-1];
              count <= CW'(WIDTH);
              Busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          acc   <= qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          dq    <= {dq[WIDTH-2:0], qbit};
          count <= count - CW'(1);
        end
        FIX: begin
          quotient  <= qneg ? -dq : dq;
          remainder <= rneg ? -acc : acc;
          Done      <= 1'b1;
          Busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed vectors for seq_div with a queue-based scoreboard.
module tb_seq_div;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        L = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient, remainder;
  logic        Busy, Done;

  seq_div #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .L(L), .Signed(Signed),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int unsigned due;
    int unsigned busy;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          errors = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per Done pulse and checks data, latency and
  // the number of cycles Busy was seen high. It also flags outputs that change
  // without a Done pulse.
  initial begin : monitor
    exp_t        e;
    int unsigned busycnt = 0;
    logic [31:0] pq = '0, pr = '0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        busycnt = 0;
      end else begin
        if (!Done && (quotient !== pq || remainder !== pr)) begin
          tests++; errors++;
          $display("FAIL hold: outputs changed without Done q=0x%08h r=0x%08h", quotient, remainder);
        end
        if (Done) begin
          if (sb.size() == 0) begin
            tests++; errors++;
            $display("FAIL unexpected_done: Done=1 with no operation pending at cycle %0d", cyc);
          end else begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("done_cycle", cyc, e.due);
            chk("busy_cycles", busycnt, e.busy);
          end
          busycnt = 0;
        end
        if (Busy) busycnt++;
      end
      pq = quotient;
      pr = remainder;
    end
  end

  // Issue one L pulse. If requested, queue the expected result, the edge count
  // at which Done must be seen, and the expected Busy length.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [31:0] eq, input logic [31:0] er, input int unsigned lat,
                    input bit push);
    exp_t e;
    @(posedge Clk); #1;
    dividend = a; divisor = b; Signed = s; L = 1'b1;
    if (push) begin
      e.q = eq; e.r = er; e.due = cyc + 1 + lat; e.busy = (lat == 1) ? 0 : lat;
      sb.push_back(e);
    end
    @(posedge Clk); #1;
    L = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++; errors++;
      $display("FAIL timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : driver
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_q", quotient, 32'h0);
    chk("reset_r", remainder, 32'h0);
    chk("reset_busy", {31'b0, Busy}, 32'h0);
    chk("reset_done", {31'b0, Done}, 32'h0);
    Rst = 1'b0;

    op(32'd3480, 32'd29, 1'b0, 32'd120, 32'd0, 33, 1'b1);              wait_done();
    op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b1); wait_done();
    op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33, 1'b1);     wait_done();
    op(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1, 1'b1); wait_done();
    op(32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1, 1'b1); wait_done();
    op(32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1, 1'b1); wait_done();
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1, 1'b1); wait_done();
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 33, 1'b1); wait_done();
    op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 33, 1'b1); wait_done();
    op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b1);                  wait_done();

    // An L pulse during CALC must be ignored.
    op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 33, 1'b1);
    repeat (8) @(posedge Clk);
    #1;
    dividend = 32'd100; divisor = 32'd7; L = 1'b1;
    @(posedge Clk); #1;
    L = 1'b0;
    wait_done();
    repeat (40) @(posedge Clk);

    // A reset during CALC aborts the operation: no Done, outputs zero at once.
    op(32'd3361, 32'd28, 1'b0, 32'd0, 32'd0, 33, 1'b0);
    repeat (13) @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    chk("abort_q", quotient, 32'h0);
    chk("abort_r", remainder, 32'h0);
    chk("abort_busy", {31'b0, Busy}, 32'h0);
    chk("abort_done", {31'b0, Done}, 32'h0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    repeat (40) @(posedge Clk);
    op(32'd3361, 32'd28, 1'b0, 32'd120, 32'd1, 33, 1'b1);               wait_done();

    repeat (3) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
